mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single cached data memory port between two requesters: port 0 is the CPU load/store unit, port 1 is the debug/DMA loader.
- Issues one access at a time to the cache and follows the cache's clk_stall miss sequence.
- Re-issues the held access after a refill and returns read data to the owning requester.
- Sits between the processor/debug masters and the cached data memory. It holds the request stable across the miss, so the masters never observe clk_stall.

Parameters:
- ADDR_W, 14, width of byte address to the cache.
- DATA_W, 32, data word width.
- STALL_TIMEOUT, 64, max consecutive stall cycles before timeout_err sets.

Ports:
- clk  in  1  system clock, all flops on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- r0_req / r1_req  in  1  access request; hold with fields stable until gnt.
- r0_addr / r1_addr  in  ADDR_W  byte address.
- r0_wdata / r1_wdata  in  DATA_W  store data.
- r0_we / r1_we  in  1  1 = store, 0 = load.
- r0_sign_mask / r1_sign_mask  in  4  size/sign code, passed through unchanged.
- r0_gnt / r1_gnt  out  1  combinational accept pulse; fields are latched this cycle.
- r0_rvalid / r1_rvalid  out  1  one-cycle completion pulse, registered.
- r0_rdata / r1_rdata  out  DATA_W  load data, valid with rvalid; 0 for stores.
- mem_addr  out  ADDR_W  to cache addr.
- mem_write_data  out  DATA_W  to cache write_data.
- mem_memwrite / mem_memread  out  1  cache strobes.
- mem_sign_mask  out  4  to cache sign_mask.
- mem_read_data  in  DATA_W  cache read_data, registered in the cache.
- mem_clk_stall  in  1  cache miss stall.
- busy  out  1  state != IDLE.
- owner  out  1  port of current or last transaction.
- timeout_err  out  1  sticky, cleared only by reset.

Behaviour:
- Reset values:
  - state = IDLE; all strobes, gnt, rvalid, busy, owner, timeout_err = 0.
  - rdata = 0; latched fields = 0; stall counter = 0.
- States:
  - IDLE: gnt is asserted only if some req=1 and mem_clk_stall=0. Winner's addr/wdata/we/sign_mask/id are latched at the edge; go to ISSUE.
  - ISSUE: drive latched fields; mem_memread=~we, mem_memwrite=we; go to CHECK.
  - CHECK: strobes low, fields held.
    - If mem_clk_stall=0 (hit): capture mem_read_data (reads) or 0 (writes) into winner's rdata; pulse winner's rvalid next cycle; go to IDLE.
    - If mem_clk_stall=1: go to WAIT.
  - WAIT: fields held.
    - While mem_clk_stall=1: strobes low, stall counter increments.
    - First cycle with mem_clk_stall=0: strobes driven combinationally (re-issue to the now-IN_CACHE cache); go to CHECK.
- mem_addr, mem_write_data and mem_sign_mask hold the latched values in every non-IDLE state; in IDLE they hold the last values.
- Latency (req high at cycle 0, granted at cycle 0):
  - hit: rvalid at cycle 3.
  - single miss (3-cycle cache stall): rvalid at cycle 6.
  - back-to-back throughput: one access per 3 cycles, because IDLE may grant in the same cycle rvalid pulses.
- Stall counter:
  - clears on each grant; saturates.
  - reaching STALL_TIMEOUT sets timeout_err.
  - the transaction is not aborted.
- Arbitration without the optional feature: fixed priority, port 0 wins ties.
- Boundary conditions:
  - Requester drops req before gnt: no access occurs.
  - mem_clk_stall=1 while IDLE (e.g. after a reset mid-miss, since the cache has no reset): no grant until it falls.
  - Reset mid-transaction: immediate return to IDLE, strobes low, rvalid lost; the requester must re-request.
  - Repeated misses in WAIT→CHECK: loop until a hit.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: one-bit last-winner pointer, reset to 1 so port 0 wins first. On simultaneous requests, the port that did not win last is granted; the pointer updates on every grant.
- Undefined: fixed priority, port 0 first; no pointer flop.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=0, ISSUE=1, CHECK=2, WAIT=3;
  - port ids PORT_CPU=0, PORT_DBG=1;
  - the sign_mask word code 4'b0111.
- Natural sub-module: mem_arb_pick. It is combinational 2-way grant selection, including the round-robin pointer flop when enabled.

Test Plan:
- Hit read: r0 load addr 0x0040, cache returns 0xDEADBEEF without stall → r0_gnt cycle 0, mem_memread cycle 1 only, r0_rvalid cycle 3 with r0_rdata=0xDEADBEEF.
- Miss write: r1 store 0x12345678 to 0x0100, stall high 3 cycles → strobes in cycles 1 and 4, r1_rvalid cycle 6, r1_rdata=0; no strobe while stall is high.
- Contention: r0 and r1 both request every cycle for 4 accesses.
  - Fixed mode: grants 0,0,0,0.
  - MEM_ARB_ROUND_ROBIN_EN: grants 0,1,0,1.
  - Each gnt follows the previous rvalid by 0 cycles.
- Timeout: hold mem_clk_stall=1 for 70 cycles after issue → timeout_err rises after 64 WAIT cycles, stays 1 after completion until rst_n.
- Reset mid-miss: assert rst_n=0 during WAIT with stall still high → all outputs 0 immediately; after release, pending r0_req is not granted until mem_clk_stall=0.
- Request withdrawal: r1_req pulses for one cycle while IDLE with stall=1 → no gnt, no strobes, busy stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the cached data memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    WAIT  = 2'd3
  } state_e;

  // Requester ids
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // sign_mask code for a full 32-bit word access
  localparam logic [3:0] SIGN_MASK_WORD = 4'b0111;

  // Control fields captured at grant and held for the whole access
  typedef struct packed {
    logic       id;
    logic       we;
    logic [3:0] sign_mask;
  } acc_ctrl_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way grant selection for mem_port_arbiter.
// MEM_ARB_ROUND_ROBIN_EN: alternate between ports on contention using a
// last-winner pointer; otherwise port 0 has fixed priority.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_c,
  output logic       win_id_c
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Grant the port that did not win last when both request
  always_comb begin
    gnt_c = '0;
    if (en) begin
      if (req == 2'b11) begin
        gnt_c = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt_c = req;
      end
    end
  end

  // Last-winner pointer; resets to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_DBG;
    end else if (|gnt_c) begin
      last_q <= gnt_c[1];
    end
  end
`else
  // Fixed priority, port 0 first
  always_comb begin
    gnt_c = '0;
    if (en) begin
      if (req[0]) begin
        gnt_c = 2'b01;
      end else if (req[1]) begin
        gnt_c = 2'b10;
      end
    end
  end
`endif

  assign win_id_c = gnt_c[1] ? PORT_DBG : PORT_CPU;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the cached data memory port between the CPU load/store unit
// (port 0) and the debug/DMA loader (port 1). One access at a time; the
// held access is re-issued after a cache refill so masters never see stall.
// Optional: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 14,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned STALL_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_we,
  input  logic [3:0]        r0_sign_mask,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_we,
  input  logic [3:0]        r1_sign_mask,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [3:0]        mem_sign_mask,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_clk_stall,
  output logic              busy,
  output logic              owner,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  acc_ctrl_t          ctrl_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         gnt_c;
  logic               win_id_c;
  logic               pick_en_c;
  logic               hit_c;

  // Grants only from IDLE and never while the cache is still stalled
  assign pick_en_c = (state_q == IDLE) && !mem_clk_stall;
  assign hit_c     = (state_q == CHECK) && !mem_clk_stall;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk      (clk),
    .rst_n    (rst_n),
`endif
    .en       (pick_en_c),
    .req      ({r1_req, r0_req}),
    .gnt_c    (gnt_c),
    .win_id_c (win_id_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and cache strobes
  always_comb begin
    state_d      = state_q;
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|gnt_c) state_d = ISSUE;
      end
      ISSUE: begin
        mem_memread  = ~ctrl_q.we;
        mem_memwrite = ctrl_q.we;
        state_d      = CHECK;
      end
      CHECK: begin
        state_d = mem_clk_stall ? WAIT : IDLE;
      end
      WAIT: begin
        // Refill done: re-issue to the cache, which now holds the line
        if (!mem_clk_stall) begin
          mem_memread  = ~ctrl_q.we;
          mem_memwrite = ctrl_q.we;
          state_d      = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, completion data and stall watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      cnt_q       <= '0;
      timeout_err <= 1'b0;
      r0_rvalid   <= 1'b0;
      r1_rvalid   <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
    end else begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      if (|gnt_c) begin
        addr_q           <= win_id_c ? r1_addr : r0_addr;
        wdata_q          <= win_id_c ? r1_wdata : r0_wdata;
        ctrl_q.id        <= win_id_c;
        ctrl_q.we        <= win_id_c ? r1_we : r0_we;
        ctrl_q.sign_mask <= win_id_c ? r1_sign_mask : r0_sign_mask;
        cnt_q            <= '0;
      end
      if (hit_c) begin
        if (ctrl_q.id == PORT_DBG) begin
          r1_rvalid <= 1'b1;
          r1_rdata  <= ctrl_q.we ? '0 : mem_read_data;
        end else begin
          r0_rvalid <= 1'b1;
          r0_rdata  <= ctrl_q.we ? '0 : mem_read_data;
        end
      end
      // Watchdog only flags; the access keeps waiting for the cache
      if ((state_q == WAIT) && mem_clk_stall) begin
        if (cnt_q != CNT_W'(STALL_TIMEOUT)) cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q >= CNT_W'(STALL_TIMEOUT - 1)) timeout_err <= 1'b1;
      end
    end
  end

  assign r0_gnt         = gnt_c[0];
  assign r1_gnt         = gnt_c[1];
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = ctrl_q.sign_mask;
  assign owner          = ctrl_q.id;
  assign busy           = (state_q != IDLE);

endmodule
